data_mem_initiator: RTL and testbench
=====================================

// Module: data_mem_initiator
// PURPOSE
//  CPU-side load/store initiator for the data memory bus (memread/memwrite/addr/write_data/sign_mask/
//  read_data/clk_stall). Accepts one load or store from the pipeline on a valid/ready handshake.
//  Encodes funct3 into sign_mask and rejects misaligned accesses. Issues a single-cycle strobe, then
//  tracks the responder's clk_stall rise/fall. Returns load data or a store completion. Errors are
//  reported for misalignment and for a responder that never acknowledges. One access in flight at a time.
// PARAMETERS
//  ACK_TIMEOUT  8   max clk cycles in ACK waiting for clk_stall=1 before error; must be >=2
//  ADDR_W       32  address / data width (bus fixed at 32; parameter for checks only)
// PORTS
//  clk          in   1   core clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   pipeline request valid
//  req_ready    out  1   high only in IDLE
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32I funct3: LB/LH/LW/LBU/LHU (load), SB/SH/SW (store)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  load result, already extended by responder; 0 for stores/errors
//  rsp_err      out  1   valid with rsp_valid: 1=misaligned or timeout
//  memread      out  1   bus read strobe (registered, one-cycle pulse)
//  memwrite     out  1   bus write strobe (registered, one-cycle pulse)
//  addr         out  32  bus address, held from ISSUE through RESP
//  write_data   out  32  bus write data, held with addr
//  sign_mask    out  4   {signed, word, half, byte}: byte=S001 half=S011 word=S111, S=~funct3[2]
//  read_data    in   32  responder load data, valid in the first cycle clk_stall is low after high
//  clk_stall    in   1   responder busy
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all outputs 0, req_ready=1 after release. Exits mid-transaction
//    immediately, with strobes low the same cycle. The responder has no reset; after a mid-op reset the
//    bench waits for clk_stall=0 before the next request.
//  States: IDLE, ISSUE, ACK, BUSY, RESP.
//  IDLE: req_ready=1. On req_valid, latch addr/write_data/sign_mask.
//    Misaligned (half: addr[0]=1; word: addr[1:0]!=0) or illegal funct3 (load 011/110/111, store >=011)
//      -> RESP with err=1; no strobe is driven.
//    Otherwise -> ISSUE, with memread=~we or memwrite=we registered high.
//  ISSUE: strobe high for exactly this cycle (cleared at the exit edge). Go to ACK and clear the timeout counter.
//  ACK: clk_stall=1 -> BUSY. Otherwise count; count==ACK_TIMEOUT-1 -> RESP err=1.
//  BUSY: clk_stall=0 -> RESP; for a load, capture read_data into rsp_rdata on this edge.
//  RESP: rsp_valid=1 for one cycle, then go to IDLE. rsp_rdata/rsp_err are held until the next RESP.
//  Strobes are never high outside ISSUE, so the responder cannot retrigger when it returns to IDLE.
//  Latency with data_mem (2-cycle stall):
//    accept edge E0; strobe high E0..E1; ACK sees stall at E2; BUSY sees stall low at E4.
//    rsp_valid is high in the cycle after E4. Misaligned request: rsp_valid in the cycle after E0.
//  req_valid while not ready is ignored (no queue). Store to 0x2000 (LED) is an ordinary store.
//  Widths: timeout counter is clog2(ACK_TIMEOUT) bits, saturating. addr is never modified (no base subtract).
// STRUCTURE
//  Shared header sail_mem_defs.vh:
//    funct3 codes (F3_LB..F3_SW) and SM_BYTE/SM_HALF/SM_WORD/SM_SIGNED sign_mask constants.
//    State encodings. data_mem adopts the same header.
//  Sub-module lsu_req_decode (combinational): funct3, addr[1:0], we -> sign_mask, misaligned, illegal.
//  FSM + timeout counter stay in data_mem_initiator.
// TESTING (bench pairs DUT with data_mem behavioural model, data.hex preloaded)
//  1 LW 0x1004 (mem word 0xDEADBEEF) -> memread one cycle; rsp_valid 4 edges after accept;
//    rsp_rdata=0xDEADBEEF, err=0.
//  2 SB 0x1005, wdata 0x000000A5 over word 0x11223344; then LBU 0x1005 -> 0x000000A5;
//    LW 0x1004 -> 0x1122A544.
//  3 LB 0x1007 on 0x80xxxxxx -> 0xFFFFFF80; LHU 0x1006 on 0x8001xxxx -> 0x00008001.
//  4 LW 0x1002 and SH 0x1001 -> no strobe ever; rsp_valid next cycle; err=1; rsp_rdata=0.
//  5 Stall model never raises clk_stall -> rsp_err=1 exactly ACK_TIMEOUT cycles after ACK entry;
//    req_ready=1 next cycle.
//  6 rst_n low during BUSY -> outputs 0 asynchronously; once clk_stall=0, next LW 0x1004 completes correctly.

Source files
------------

// File: rtl/data_mem_initiator_pkg.sv
// data_mem_initiator_pkg: funct3 codes, sign_mask encodings and FSM states shared by the load/store initiator
package data_mem_initiator_pkg;
  localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010;
  localparam logic [3:0] SM_BYTE = 4'b0001, SM_HALF = 4'b0011, SM_WORD = 4'b0111, SM_SIGNED = 4'b1000;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_BUSY, S_RESP} state_t;
endpackage

// File: rtl/data_mem_initiator_lsu_req_decode.sv
// lsu_req_decode: maps funct3/addr/we to the bus sign_mask and flags misaligned or illegal requests
module lsu_req_decode
  import data_mem_initiator_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  logic       we,
  output logic [3:0] sign_mask,
  output logic       misaligned,
  output logic       illegal
);
  logic word, half;
  assign word = funct3[1:0] == F3_LW[1:0];
  assign half = funct3[1:0] == F3_LH[1:0];
  assign sign_mask = (word ? SM_WORD : half ? SM_HALF : SM_BYTE) | (funct3[2] ? 4'b0000 : SM_SIGNED);
  assign misaligned = (half && addr_lo[0]) || (word && addr_lo != 2'b00);
  assign illegal = we ? !(funct3 inside {F3_SB, F3_SH, F3_SW})
                      : !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
endmodule

// File: rtl/data_mem_initiator.sv
// data_mem_initiator: single-outstanding load/store initiator driving the data memory strobe/stall bus
module data_mem_initiator
  import data_mem_initiator_pkg::*;
#(
  parameter int ACK_TIMEOUT = 8,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       write_data,
  output logic [3:0]        sign_mask,
  input  logic [31:0]       read_data,
  input  logic              clk_stall
);
  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] dec_mask;
  logic mis, ill, we_q;
  lsu_req_decode u_dec (
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .we        (req_we),
    .sign_mask (dec_mask),
    .misaligned(mis),
    .illegal   (ill)
  );
  assign req_ready = rst_n && state == S_IDLE;
  assign rsp_valid = state == S_RESP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = !req_valid ? S_IDLE : (mis || ill) ? S_RESP : S_ISSUE;
      S_ISSUE: state_n = S_ACK;
      S_ACK:   state_n = clk_stall ? S_BUSY : cnt == LAST ? S_RESP : S_ACK;
      S_BUSY:  state_n = clk_stall ? S_BUSY : S_RESP;
      default: state_n = S_IDLE;
    endcase
  end
  // Strobes are only ever set on the accept edge, so they are high for the ISSUE cycle alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      addr       <= '0;
      write_data <= '0;
      sign_mask  <= '0;
      we_q       <= 1'b0;
      cnt        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      memread  <= state == S_IDLE && state_n == S_ISSUE && !req_we;
      memwrite <= state == S_IDLE && state_n == S_ISSUE && req_we;
      if (state == S_IDLE && req_valid) begin
        addr       <= req_addr;
        write_data <= req_wdata;
        sign_mask  <= dec_mask;
        we_q       <= req_we;
      end
      cnt <= state != S_ACK ? '0 : cnt == LAST ? cnt : cnt + 1'b1;
      if (state_n == S_RESP && state != S_RESP) begin
        rsp_err   <= state != S_BUSY;
        rsp_rdata <= (state == S_BUSY && !we_q) ? read_data : 32'h0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_initiator.sv
// tb_data_mem_initiator: pairs the initiator with a stalling data memory responder and a byte-level reference model
module tb_data_mem_initiator;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic req_ready, rsp_valid, rsp_err, memread, memwrite;
  logic [31:0] rsp_rdata, addr, write_data;
  logic [3:0] sign_mask;
  logic [31:0] read_data = 32'h0;
  logic clk_stall = 1'b0;
  logic resp_en = 1'b1;
  logic bd_we = 1'b0;
  logic [13:0] bd_a = '0;
  logic [31:0] bd_w = '0;
  logic [7:0] mem [0:16383];
  logic [7:0] ref_mem [0:16383];
  logic [1:0] n = '0;
  logic op_we = 1'b0;
  logic [13:0] op_a = '0;
  logic [3:0] op_m = '0;
  logic [31:0] op_wd = '0;
  int rd_cnt = 0, wr_cnt = 0;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  data_mem_initiator #(.ACK_TIMEOUT(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .memread(memread), .memwrite(memwrite), .addr(addr),
    .write_data(write_data), .sign_mask(sign_mask), .read_data(read_data), .clk_stall(clk_stall)
  );

  function automatic logic [31:0] bus_load(input logic [13:0] a, input logic [3:0] m);
    logic [31:0] w;
    w = {mem[14'(a + 3)], mem[14'(a + 2)], mem[14'(a + 1)], mem[a]};
    return m[2] ? w : m[1] ? {{16{m[3] & w[15]}}, w[15:0]} : {{24{m[3] & w[7]}}, w[7:0]};
  endfunction

  // Responder: raises clk_stall the edge after a strobe, holds it two cycles, data valid once it drops.
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_a] <= bd_w[7:0];
      mem[14'(bd_a + 1)] <= bd_w[15:8];
      mem[14'(bd_a + 2)] <= bd_w[23:16];
      mem[14'(bd_a + 3)] <= bd_w[31:24];
    end else if (clk_stall) begin
      if (n == 0) begin
        clk_stall <= 1'b0;
        if (op_we) begin
          mem[op_a] <= op_wd[7:0];
          if (op_m[1]) mem[14'(op_a + 1)] <= op_wd[15:8];
          if (op_m[2]) begin
            mem[14'(op_a + 2)] <= op_wd[23:16];
            mem[14'(op_a + 3)] <= op_wd[31:24];
          end
        end else read_data <= bus_load(op_a, op_m);
      end else n <= n - 1;
    end else if (resp_en && (memread || memwrite)) begin
      clk_stall <= 1'b1;
      n <= 2'd1;
      op_we <= memwrite;
      op_a <= addr[13:0];
      op_m <= sign_mask;
      op_wd <= write_data;
    end
  end

  always @(negedge clk) begin
    rd_cnt += int'(memread);
    wr_cnt += int'(memwrite);
  end

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    longint v;
    sz = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_mem[14'(a + i)]) << (8 * i);
    if (!f3[2] && v >= (64'd1 << (8 * sz - 1))) v -= (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[14'(a + i)] = 8'(wd >> (8 * i));
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    bd_we = 1'b1; bd_a = a[13:0]; bd_w = w;
    for (int i = 0; i < 4; i++) ref_mem[14'(a + i)] = 8'(w >> (8 * i));
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic e, output int nrd, output int nwr,
                        output logic [31:0] ra, output logic [3:0] sm, output logic rdy_at, output logic rdy_next,
                        output logic vld_next);
    int r0, w0, k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    r0 = rd_cnt; w0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata; e = rsp_err; ra = addr; sm = sign_mask; rdy_at = req_ready;
    @(negedge clk);
    #1;
    rdy_next = req_ready; vld_next = rsp_valid;
    nrd = rd_cnt - r0; nwr = wr_cnt - w0;
  endtask

  int lat, nrd, nwr;
  logic [31:0] rd, ra;
  logic e, ra_, rn, vn;
  logic [3:0] sm;

  task automatic test_reset();
    #3;
    total++; if ({req_ready, rsp_valid, rsp_err, memread, memwrite} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {req_ready, rsp_valid, rsp_err, memread, memwrite}); else passed++;
    total++; if ({addr, write_data, rsp_rdata, sign_mask} !== 100'b0) $display("FAIL reset_data got addr=%h wd=%h rd=%h sm=%b want 0", addr, write_data, rsp_rdata, sign_mask); else passed++;
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_lw();
    do_req(1'b0, 3'b010, 32'h1004, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (lat !== 4) $display("FAIL lw_latency got %0d want 4", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL lw_data got %h err=%b want deadbeef err=0", rd, e); else passed++;
    total++; if (nrd !== 1 || nwr !== 0) $display("FAIL lw_strobes got rd=%0d wr=%0d want 1/0", nrd, nwr); else passed++;
    total++; if (ra !== 32'h1004 || sm !== 4'b1111) $display("FAIL lw_bus got addr=%h sm=%b want 1004/1111", ra, sm); else passed++;
    total++; if (ra_ !== 1'b0 || rn !== 1'b1 || vn !== 1'b0) $display("FAIL lw_handshake got rdy=%b rdy_next=%b vld_next=%b want 0/1/0", ra_, rn, vn); else passed++;
  endtask

  task automatic test_store_load();
    set_word(32'h1004, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h1005, 32'h000000A5, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    ref_store(3'b000, 32'h1005, 32'hA5);
    total++; if (lat !== 4 || e !== 1'b0 || rd !== 32'h0) $display("FAIL sb_resp got lat=%0d err=%b rd=%h want 4/0/0", lat, e, rd); else passed++;
    total++; if (nrd !== 0 || nwr !== 1 || sm !== 4'b1001) $display("FAIL sb_strobes got rd=%0d wr=%0d sm=%b want 0/1/1001", nrd, nwr, sm); else passed++;
    do_req(1'b0, 3'b100, 32'h1005, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (rd !== 32'h000000A5 || e !== 1'b0) $display("FAIL lbu_after_sb got %h want 000000a5", rd); else passed++;
    do_req(1'b0, 3'b010, 32'h1004, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (rd !== 32'h1122A544) $display("FAIL lw_after_sb got %h want 1122a544", rd); else passed++;
    do_req(1'b1, 3'b010, 32'h2000, 32'h0000_00FF, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    ref_store(3'b010, 32'h2000, 32'hFF);
    do_req(1'b0, 3'b010, 32'h2000, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (rd !== 32'h000000FF || e !== 1'b0) $display("FAIL led_store got %h want 000000ff", rd); else passed++;
  endtask

  task automatic test_signext();
    set_word(32'h1004, 32'h80017766);
    do_req(1'b0, 3'b000, 32'h1007, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_sign got %h want ffffff80", rd); else passed++;
    do_req(1'b0, 3'b101, 32'h1006, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (rd !== 32'h00008001 || sm !== 4'b0011) $display("FAIL lhu_zero got %h sm=%b want 00008001/0011", rd, sm); else passed++;
    do_req(1'b0, 3'b001, 32'h1006, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (rd !== 32'hFFFF8001) $display("FAIL lh_sign got %h want ffff8001", rd); else passed++;
  endtask

  task automatic test_misaligned();
    do_req(1'b0, 3'b010, 32'h1002, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (lat !== 0 || e !== 1'b1 || rd !== 32'h0) $display("FAIL lw_misaligned got lat=%0d err=%b rd=%h want 0/1/0", lat, e, rd); else passed++;
    total++; if (nrd !== 0 || nwr !== 0 || ra !== 32'h1002) $display("FAIL lw_mis_strobe got rd=%0d wr=%0d addr=%h want 0/0/1002", nrd, nwr, ra); else passed++;
    do_req(1'b1, 3'b001, 32'h1001, 32'h1234, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (lat !== 0 || e !== 1'b1 || rd !== 32'h0 || nwr !== 0) $display("FAIL sh_misaligned got lat=%0d err=%b rd=%h wr=%0d want 0/1/0/0", lat, e, rd, nwr); else passed++;
    do_req(1'b0, 3'b110, 32'h1000, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (lat !== 0 || e !== 1'b1 || nrd !== 0) $display("FAIL illegal_load got lat=%0d err=%b rd=%0d want 0/1/0", lat, e, nrd); else passed++;
    do_req(1'b1, 3'b011, 32'h1000, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (lat !== 0 || e !== 1'b1 || nwr !== 0) $display("FAIL illegal_store got lat=%0d err=%b wr=%0d want 0/1/0", lat, e, nwr); else passed++;
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    do_req(1'b0, 3'b010, 32'h1008, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    resp_en = 1'b1;
    total++; if (lat !== 9) $display("FAIL timeout_latency got %0d want 9", lat); else passed++;
    total++; if (e !== 1'b1 || rd !== 32'h0 || nrd !== 1) $display("FAIL timeout_resp got err=%b rd=%h strobes=%0d want 1/0/1", e, rd, nrd); else passed++;
    total++; if (ra_ !== 1'b0 || rn !== 1'b1) $display("FAIL timeout_ready got %b->%b want 0->1", ra_, rn); else passed++;
  endtask

  task automatic test_random();
    logic we;
    logic [2:0] f3;
    logic [31:0] a, wd, exp_rd;
    logic legal, err;
    int sz, errs;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      a = 32'h1000 + $urandom_range(0, 252);
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err = !legal || (a % sz) != 0;
      exp_rd = (!err && !we) ? ref_load(f3, a) : 32'h0;
      if (!err && we) ref_store(f3, a, wd);
      do_req(we, f3, a, wd, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
      total++;
      if (rd !== exp_rd || e !== err || lat !== (err ? 0 : 4) || nrd !== int'(!err && !we) || nwr !== int'(!err && we)) begin
        $display("FAIL random_%0d we=%b f3=%b a=%h got rd=%h err=%b lat=%0d strb=%0d/%0d want rd=%h err=%b lat=%0d",
                 i, we, f3, a, rd, e, lat, nrd, nwr, exp_rd, err, err ? 0 : 4);
        errs++;
      end else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_req(1'b0, 3'b010, 32'h1004, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1004;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!clk_stall && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    total++; if (clk_stall !== 1'b1) $display("FAIL reset_mid_busy got stall=%b want 1", clk_stall); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({req_ready, rsp_valid, rsp_err, memread, memwrite} !== 5'b0 || rsp_rdata !== 32'h0 || addr !== 32'h0) $display("FAIL reset_mid_outputs got ctl=%b rd=%h addr=%h want 0", {req_ready, rsp_valid, rsp_err, memread, memwrite}, rsp_rdata, addr); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (clk_stall && k < 20) begin @(negedge clk); k++; end
    do_req(1'b0, 3'b010, 32'h1004, 32'h0, lat, rd, e, nrd, nwr, ra, sm, ra_, rn, vn);
    total++; if (rd !== ref_load(3'b010, 32'h1004) || e !== 1'b0 || lat !== 4) $display("FAIL reset_mid_recover got rd=%h err=%b lat=%0d want %h/0/4", rd, e, lat, ref_load(3'b010, 32'h1004)); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h0;
    for (int w = 0; w < 64; w++) set_word(32'h1000 + 32'(4 * w), $urandom);
    set_word(32'h1004, 32'hDEADBEEF);
    set_word(32'h2000, 32'h0);
    test_reset();
    test_lw();
    test_store_load();
    test_signext();
    test_misaligned();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
